vram_cpu_port: RTL and testbench

// - CPU-side port of the screen RAM (1 KB) and character RAM (1 KB); the video generator owns the other port.
// - Decodes Z80 memory cycles in 0x2000-0x2FFF, performs reads and writes, stalls the CPU with wait_n.
// - Models the Ace split: 0x2000/0x2800 halves are CPU-priority, 0x2400/0x2C00 halves are video-priority.

---
 rtl/vram_cpu_port.sv | 128 ++++++++++++
 tb/tb_vram_cpu_port.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_cpu_port.sv
// Z80-side port onto the screen and character RAMs (0x2000-0x2FFF).
// Requests to video-priority halves wait on WAIT while the display is fetching.
module vram_cpu_port #(
  parameter int PRIO_SPLIT = 1,
  parameter int MAX_WAIT   = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce_cpu,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        mreq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        disp_active,
  input  logic [7:0]  scr_rdata,
  output logic [9:0]  scr_addr,
  output logic [7:0]  scr_wdata,
  output logic        scr_we,
  output logic [9:0]  chr_addr,
  output logic [7:0]  chr_wdata,
  output logic        chr_we,
  output logic [7:0]  cpu_din,
  output logic        cpu_sel,
  output logic        wait_n,
  output logic        vid_glitch
);

  localparam int            CW    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] MAX_W = CW'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, STALL, ACCESS, HOLD} state_t;

  state_t        r_state;
  logic          r_is_wr;
  logic          r_is_chr;
  logic [CW-1:0] r_cnt;
  logic          r_wait_n;
  logic          r_scr_we;
  logic          r_chr_we;
  logic          r_glitch;
  logic [7:0]    r_din;

  logic          w_in_range;
  logic          w_hit;
  logic          w_vid_prio;
  logic [CW-1:0] w_cnt_inc;
  logic          w_force;

  assign w_in_range = !mreq_n && (cpu_addr[15:12] == 4'h2);
  assign w_hit      = w_in_range && (!rd_n || !wr_n);
  assign w_vid_prio = cpu_addr[10] && (PRIO_SPLIT != 0);
  // Saturating stall counter; with MAX_WAIT=0 it never forces an access.
  assign w_cnt_inc  = (r_cnt == MAX_W) ? r_cnt : r_cnt + 1'b1;
  assign w_force    = (MAX_WAIT > 0) && (w_cnt_inc == MAX_W);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_is_wr  <= 1'b0;
      r_is_chr <= 1'b0;
      r_cnt    <= '0;
      r_wait_n <= 1'b1;
      r_scr_we <= 1'b0;
      r_chr_we <= 1'b0;
      r_glitch <= 1'b0;
      r_din    <= 8'hFF;
    end else begin
      r_scr_we <= 1'b0;
      r_chr_we <= 1'b0;
      r_glitch <= 1'b0;
      if (ce_cpu) begin
        case (r_state)
          IDLE: begin
            if (w_hit) begin
              r_is_wr  <= !wr_n;
              r_is_chr <= cpu_addr[11];
              r_wait_n <= 1'b0;
              if (w_vid_prio && disp_active) begin
                r_state <= STALL;
                r_cnt   <= '0;
              end else begin
                r_state  <= ACCESS;
                r_glitch <= disp_active;
              end
            end
          end
          STALL: begin
            // CPU abandoned the cycle: drop it without touching the RAM.
            if (mreq_n) begin
              r_state  <= IDLE;
              r_wait_n <= 1'b1;
            end else begin
              r_cnt <= w_cnt_inc;
              if (!disp_active || w_force) r_state <= ACCESS;
            end
          end
          ACCESS: begin
            r_state  <= HOLD;
            r_wait_n <= 1'b1;
            if (r_is_wr) begin
              r_scr_we <= !r_is_chr;
              r_chr_we <= r_is_chr;
            end else begin
              r_din <= r_is_chr ? 8'hFF : scr_rdata;
            end
          end
          HOLD: begin
            if (mreq_n) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign scr_addr   = cpu_addr[9:0];
  assign scr_wdata  = cpu_dout;
  assign chr_addr   = cpu_addr[9:0];
  assign chr_wdata  = cpu_dout;
  assign scr_we     = r_scr_we;
  assign chr_we     = r_chr_we;
  assign cpu_din    = r_din;
  assign cpu_sel    = w_in_range && !rd_n && wr_n;
  assign wait_n     = r_wait_n;
  assign vid_glitch = r_glitch;

endmodule

// File: tb/tb_vram_cpu_port.sv
// Bench for vram_cpu_port: directed table, MAX_WAIT/reset sequences and
// random bus cycles checked against a transaction-level model.
module tb_vram_cpu_port;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce_cpu = 1'b0;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        mreq_n, rd_n, wr_n, disp_active;
  logic [7:0]  scr_rdata;
  logic [9:0]  scr_addr, chr_addr;
  logic [7:0]  scr_wdata, chr_wdata, cpu_din;
  logic        scr_we, chr_we, cpu_sel, wait_n, vid_glitch;

  logic [9:0]  d8_scr_addr, d8_chr_addr;
  logic [7:0]  d8_scr_wdata, d8_chr_wdata, d8_cpu_din;
  logic        d8_scr_we, d8_chr_we, d8_cpu_sel, d8_wait_n, d8_vid_glitch;

  always #5 clk = ~clk;
  always @(posedge clk) ce_cpu <= ~ce_cpu;

  vram_cpu_port dut (
    .clk(clk), .reset_n(reset_n), .ce_cpu(ce_cpu), .cpu_addr(cpu_addr),
    .cpu_dout(cpu_dout), .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n),
    .disp_active(disp_active), .scr_rdata(scr_rdata), .scr_addr(scr_addr),
    .scr_wdata(scr_wdata), .scr_we(scr_we), .chr_addr(chr_addr),
    .chr_wdata(chr_wdata), .chr_we(chr_we), .cpu_din(cpu_din),
    .cpu_sel(cpu_sel), .wait_n(wait_n), .vid_glitch(vid_glitch)
  );

  vram_cpu_port #(.PRIO_SPLIT(1), .MAX_WAIT(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .ce_cpu(ce_cpu), .cpu_addr(cpu_addr),
    .cpu_dout(cpu_dout), .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n),
    .disp_active(disp_active), .scr_rdata(scr_rdata), .scr_addr(d8_scr_addr),
    .scr_wdata(d8_scr_wdata), .scr_we(d8_scr_we), .chr_addr(d8_chr_addr),
    .chr_wdata(d8_chr_wdata), .chr_we(d8_chr_we), .cpu_din(d8_cpu_din),
    .cpu_sel(d8_cpu_sel), .wait_n(d8_wait_n), .vid_glitch(d8_vid_glitch)
  );

  // Screen RAM with one-clk registered read, written only by the main DUT.
  logic [7:0] ram [0:1023];
  always @(posedge clk) begin
    if (scr_we) ram[scr_addr] <= scr_wdata;
    scr_rdata <= ram[scr_addr];
  end

  // Pulse counters sampled just after each rising edge.
  int         scr_cnt, chr_cnt, gl_cnt, scr8_cnt;
  logic [9:0] last_waddr, last_caddr;
  logic [7:0] last_wdata, last_cdata;
  always @(posedge clk) begin
    #1;
    if (scr_we) begin scr_cnt++; last_waddr = scr_addr; last_wdata = scr_wdata; end
    if (chr_we) begin chr_cnt++; last_caddr = chr_addr; last_cdata = chr_wdata; end
    if (vid_glitch) gl_cnt++;
    if (d8_scr_we) scr8_cnt++;
  end

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [7:0]  data;
    int          disp;
    int          wt;
    int          scr;
    int          chr;
    int          gl;
    logic [7:0]  din;
    logic        sel;
  } vec_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] model_mem [0:1023];
  logic [7:0] m_din;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance to just after the next rising edge on which ce_cpu is high.
  task automatic ce_tick();
    while (ce_cpu !== 1'b1) @(negedge clk);
    @(negedge clk);
  endtask

  // Spec-level model of one Z80 bus cycle with the display busy for dt ticks.
  task automatic model(input logic [15:0] a, input logic w, input logic [7:0] d,
                       input int dt, output vec_t e);
    logic in_r, stall;
    in_r   = (a[15:12] == 4'h2);
    stall  = in_r && a[10] && (dt > 0);
    e.addr = a; e.wr = w; e.data = d; e.disp = dt;
    e.wt   = !in_r ? 0 : (stall ? dt + 1 : 1);
    e.scr  = (in_r && w && !a[11]) ? 1 : 0;
    e.chr  = (in_r && w && a[11]) ? 1 : 0;
    e.gl   = (in_r && !stall && dt > 0) ? 1 : 0;
    e.sel  = in_r && !w;
    if (in_r && !w) m_din = a[11] ? 8'hFF : model_mem[a[9:0]];
    if (e.scr == 1) model_mem[a[9:0]] = d;
    e.din  = m_din;
  endtask

  task automatic run_cycle(input logic [15:0] a, input logic w, input logic [7:0] d,
                           input int dt, output int wt, output logic sel);
    scr_cnt = 0; chr_cnt = 0; gl_cnt = 0;
    cpu_addr = a; cpu_dout = d; mreq_n = 1'b0; wr_n = !w; rd_n = w;
    disp_active = (dt > 0);
    #1 sel = cpu_sel;
    wt = 0;
    for (int t = 0; t < 200; t++) begin
      disp_active = (t < dt);
      ce_tick();
      if (wait_n == 1'b0) wt++;
      else break;
    end
    mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; disp_active = 1'b0;
    ce_tick();
    ce_tick();
  endtask

  task automatic run_check(input vec_t v);
    int   wt;
    logic sel;
    run_cycle(v.addr, v.wr, v.data, v.disp, wt, sel);
    $display("[TB] txn addr=%h wr=%0d data=%h disp=%0d wait=%0d din=%h",
             v.addr, v.wr, v.data, v.disp, wt, cpu_din);
    chk($sformatf("wait_ticks@%h", v.addr), wt, v.wt);
    chk($sformatf("scr_we_pulses@%h", v.addr), scr_cnt, v.scr);
    chk($sformatf("chr_we_pulses@%h", v.addr), chr_cnt, v.chr);
    chk($sformatf("vid_glitch@%h", v.addr), gl_cnt, v.gl);
    chk($sformatf("cpu_din@%h", v.addr), cpu_din, v.din);
    chk($sformatf("cpu_sel@%h", v.addr), sel, v.sel);
    if (v.scr == 1) begin
      chk($sformatf("scr_addr@%h", v.addr), last_waddr, v.addr[9:0]);
      chk($sformatf("scr_wdata@%h", v.addr), last_wdata, v.data);
    end
    if (v.chr == 1) begin
      chk($sformatf("chr_addr@%h", v.addr), last_caddr, v.addr[9:0]);
      chk($sformatf("chr_wdata@%h", v.addr), last_cdata, v.data);
    end
  endtask

  vec_t vec [10];
  vec_t e;
  int   hit, r;
  logic [15:0] ra;

  initial begin
    for (int i = 0; i < 1024; i++) begin ram[i] = 8'h00; model_mem[i] = 8'h00; end
    m_din = 8'hFF;
    reset_n = 1'b0; cpu_addr = 16'h0000; cpu_dout = 8'h00;
    mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; disp_active = 1'b0;

    //            addr     wr    data   dp  wt  scr chr gl  din    sel
    vec[0] = '{16'h2405, 1'b1, 8'h41, 0,  1,  1,  0,  0, 8'hFF, 1'b0};
    vec[1] = '{16'h2405, 1'b0, 8'h00, 20, 21, 0,  0,  0, 8'h41, 1'b1};
    vec[2] = '{16'h2810, 1'b1, 8'hAA, 1,  1,  0,  1,  1, 8'h41, 1'b0};
    vec[3] = '{16'h2C00, 1'b0, 8'h00, 0,  1,  0,  0,  0, 8'hFF, 1'b1};
    vec[4] = '{16'h3000, 1'b0, 8'h00, 0,  0,  0,  0,  0, 8'hFF, 1'b0};
    vec[5] = '{16'h2005, 1'b0, 8'h00, 3,  1,  0,  0,  1, 8'h41, 1'b1};
    vec[6] = '{16'h2406, 1'b1, 8'hC3, 5,  6,  1,  0,  0, 8'h41, 1'b0};
    vec[7] = '{16'h2006, 1'b0, 8'h00, 0,  1,  0,  0,  0, 8'hC3, 1'b1};
    vec[8] = '{16'h1FFF, 1'b1, 8'h77, 0,  0,  0,  0,  0, 8'hC3, 1'b0};
    vec[9] = '{16'h2FFF, 1'b0, 8'h00, 2,  3,  0,  0,  0, 8'hFF, 1'b1};

    repeat (4) @(negedge clk);
    chk("reset_wait_n", wait_n, 1'b1);
    chk("reset_scr_we", scr_we, 1'b0);
    chk("reset_chr_we", chr_we, 1'b0);
    chk("reset_cpu_din", cpu_din, 8'hFF);
    chk("reset_vid_glitch", vid_glitch, 1'b0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_check(vec[i]);
      model(vec[i].addr, vec[i].wr, vec[i].data, vec[i].disp, e);
    end

    // MAX_WAIT=8 instance forces the write through; the unlimited one aborts.
    scr_cnt = 0; scr8_cnt = 0; hit = -1;
    cpu_addr = 16'h2400; cpu_dout = 8'h5A; mreq_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1;
    disp_active = 1'b1;
    for (int t = 0; t < 14; t++) begin
      ce_tick();
      if (scr8_cnt > 0 && hit < 0) hit = t;
    end
    $display("[TB] txn maxwait addr=2400 we_tick=%0d", hit);
    chk("maxwait_we_tick", hit, 9);
    chk("maxwait_we_count", scr8_cnt, 1);
    chk("unlimited_still_waiting", wait_n, 1'b0);
    mreq_n = 1'b1; wr_n = 1'b1;
    ce_tick();
    chk("abort_wait_release", wait_n, 1'b1);
    disp_active = 1'b0;
    ce_tick();
    chk("abort_no_write", scr_cnt, 0);

    // Async reset during a stalled write.
    scr_cnt = 0;
    cpu_addr = 16'h2401; cpu_dout = 8'h99; mreq_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1;
    disp_active = 1'b1;
    repeat (3) ce_tick();
    chk("stall_wait_low", wait_n, 1'b0);
    #3 reset_n = 1'b0;
    #1;
    chk("async_reset_wait_n", wait_n, 1'b1);
    chk("async_reset_cpu_din", cpu_din, 8'hFF);
    repeat (3) @(negedge clk);
    mreq_n = 1'b1; wr_n = 1'b1; disp_active = 1'b0;
    reset_n = 1'b1;
    repeat (3) ce_tick();
    $display("[TB] txn reset-during-stall addr=2401 scr_we=%0d", scr_cnt);
    chk("reset_lost_write", scr_cnt, 0);
    m_din = 8'hFF;

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 5);
      if (r < 4) ra = 16'h2000 | (16'(r) << 10) | 16'($urandom_range(0, 1023));
      else if (r == 4) ra = 16'h3000 | 16'($urandom_range(0, 4095));
      else ra = 16'h1000 | 16'($urandom_range(0, 4095));
      model(ra, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 6)), e);
      run_check(e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
